cache_l2_arbiter: RTL

Two-port arbiter sharing the unified L2 cache between the L1 instruction cache and the L1 data cache. It sits between both L1 miss ports and the L2 cache controller's CPU-side port (`mem_read`/`mem_write`/`mem_resp`). It serialises line-sized requests, holds each grant until the L2 responds, and routes the response back. Contention is resolved round-robin, and saturating service and contention counters are kept for performance debug.

---
 rtl/cache_l2_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cache_l2_arbiter.sv
// Two-port round-robin arbiter sharing the unified L2 between the L1 I-cache
// and L1 D-cache. Holds each grant until the L2 responds and routes the
// response back. Also keeps saturating service and contention counters.
module cache_l2_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache miss port
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache miss / write-back port
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // L2 controller CPU-side port
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  // performance counters
  output logic [CNT_W-1:0]  i_served_cnt,
  output logic [CNT_W-1:0]  d_served_cnt,
  output logic [CNT_W-1:0]  contention_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_d;       // 1: D port was served most recently
  logic   i_done_c;
  logic   d_done_c;
  logic   tie_c;
  logic   i_req_c;
  logic   d_req_c;

  assign i_req_c = i_read;
  assign d_req_c = d_read | d_write;

  // Read data is broadcast to both ports; only x_resp qualifies it.
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  // State, round-robin pointer and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_d         <= 1'b1;
      i_served_cnt   <= '0;
      d_served_cnt   <= '0;
      contention_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (i_done_c) begin
        last_d <= 1'b0;
        if (i_served_cnt != '1) i_served_cnt <= i_served_cnt + CNT_W'(1);
      end
      if (d_done_c) begin
        last_d <= 1'b1;
        if (d_served_cnt != '1) d_served_cnt <= d_served_cnt + CNT_W'(1);
      end
      if (tie_c && (contention_cnt != '1)) begin
        contention_cnt <= contention_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state, L2 request mux and response routing.
  always_comb begin
    state_nxt  = state;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    i_done_c   = 1'b0;
    d_done_c   = 1'b0;
    tie_c      = 1'b0;
    case (state)
      IDLE: begin
        if (i_req_c && d_req_c) begin
          tie_c     = 1'b1;
          state_nxt = last_d ? SERVE_I : SERVE_D;
        end else if (i_req_c) begin
          state_nxt = SERVE_I;
        end else if (d_req_c) begin
          state_nxt = SERVE_D;
        end
      end
      SERVE_I: begin
        l2_read    = i_read;
        l2_address = i_address;
        if (l2_resp) begin
          i_resp    = 1'b1;
          i_done_c  = 1'b1;
          state_nxt = RELEASE;
        end
      end
      SERVE_D: begin
        l2_read    = d_read;
        l2_write   = d_write;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        if (l2_resp) begin
          d_resp    = 1'b1;
          d_done_c  = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        // One quiet cycle so the requester can drop its request.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
